// File: rtl/drum_strike_detector.sv
// drum_strike_detector: turns downward gyro-Y swings into one-cycle strike
// events tagged with a yaw zone and a velocity derived from the swing peak.
//
// state   | meaning
// IDLE    | waiting for a good sample below the strike threshold
// STRIKE  | swing in progress, tracking the most negative gyro_y
// REFRACT | ignoring samples until the refract counter expires
module drum_strike_detector #(
  parameter logic signed [15:0] STRIKE_THRESH      = -16'sd3000,
  parameter logic signed [15:0] RELEASE_THRESH     = -16'sd500,
  parameter int                 MAX_STRIKE_SAMPLES = 16,
  parameter int                 REFRACT_SAMPLES    = 4,
  parameter int                 VEL_SHIFT          = 8,
  parameter logic signed [15:0] ZONE_B0            = -16'sd4500,
  parameter logic signed [15:0] ZONE_B1            = 16'sd0,
  parameter logic signed [15:0] ZONE_B2            = 16'sd4500,
  parameter logic [15:0]        COUNT_RESET        = 16'h0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sample_strobe,
  input  logic               euler_valid,
  input  logic               gyro_valid,
  input  logic               link_error,
  input  logic signed [15:0] yaw,
  input  logic signed [15:0] gyro_y,
  output logic               strike_valid,
  output logic [1:0]         strike_zone,
  output logic [6:0]         strike_velocity,
  output logic [15:0]        strike_count,
  output logic               busy
);

  localparam int SCW = $clog2(MAX_STRIKE_SAMPLES + 1);
  localparam int RCW = $clog2(REFRACT_SAMPLES + 1);
  localparam logic [SCW-1:0] SMP_ABORT = SCW'(MAX_STRIKE_SAMPLES - 1);
  localparam logic [RCW-1:0] REF_INIT  = RCW'(REFRACT_SAMPLES);

  typedef enum logic [1:0] {IDLE, STRIKE, REFRACT} state_t;

  state_t             state;
  logic signed [15:0] peak;
  logic [1:0]         zone_lat;
  logic [SCW-1:0]     smp_cnt;
  logic [RCW-1:0]     ref_cnt;
  logic               good;

  assign good = sample_strobe & euler_valid & gyro_valid & ~link_error;

  function automatic logic [1:0] zone_of(input logic signed [15:0] y);
    if (y < ZONE_B0)      return 2'd0;
    else if (y < ZONE_B1) return 2'd1;
    else if (y < ZONE_B2) return 2'd2;
    else                  return 2'd3;
  endfunction

  // 17-bit negate so that a peak of -32768 yields magnitude 32768
  function automatic logic [6:0] vel_of(input logic signed [15:0] p);
    logic [16:0] mag;
    logic [16:0] v;
    mag = 17'd0 - {p[15], p};
    v   = mag >> VEL_SHIFT;
    if (v > 17'd127)     return 7'd127;
    else if (v == 17'd0) return 7'd1;
    else                 return v[6:0];
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      busy            <= 1'b0;
      peak            <= '0;
      zone_lat        <= '0;
      smp_cnt         <= '0;
      ref_cnt         <= '0;
      strike_valid    <= 1'b0;
      strike_zone     <= '0;
      strike_velocity <= '0;
      strike_count    <= COUNT_RESET;
    end else begin
      strike_valid <= 1'b0;
      if (link_error) begin
        state   <= IDLE;
        busy    <= 1'b0;
        smp_cnt <= '0;
        ref_cnt <= '0;
      end else if (sample_strobe) begin
        case (state)
          IDLE: begin
            if (good && gyro_y < STRIKE_THRESH) begin
              peak     <= gyro_y;
              zone_lat <= zone_of(yaw);
              smp_cnt  <= '0;
              state    <= STRIKE;
              busy     <= 1'b1;
            end
          end
          STRIKE: begin
            if (!good) begin
              state   <= IDLE;
              busy    <= 1'b0;
              smp_cnt <= '0;
            end else if (gyro_y > RELEASE_THRESH) begin
              strike_valid    <= 1'b1;
              strike_zone     <= zone_lat;
              strike_velocity <= vel_of(peak);
              strike_count    <= strike_count + 1'b1;
              smp_cnt         <= '0;
              ref_cnt         <= REF_INIT;
              state           <= REFRACT;
            end else begin
              if (gyro_y < peak) peak <= gyro_y;
              smp_cnt <= smp_cnt + 1'b1;
              if (smp_cnt == SMP_ABORT) begin
                ref_cnt <= REF_INIT;
                state   <= REFRACT;
              end
            end
          end
          REFRACT: begin
            // every strobe counts here, good or not
            if (ref_cnt <= RCW'(1)) begin
              ref_cnt <= '0;
              state   <= IDLE;
              busy    <= 1'b0;
            end else begin
              ref_cnt <= ref_cnt - 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_drum_strike_detector.sv
// Bench for drum_strike_detector: directed scenarios plus random packets,
// all checked every cycle against a swing-list reference model.
module tb_drum_strike_detector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset, sample_strobe, euler_valid, gyro_valid, link_error;
  logic signed [15:0] yaw, gyro_y;
  logic               strike_valid, busy, strike_valid_b, busy_b;
  logic [1:0]         strike_zone, strike_zone_b;
  logic [6:0]         strike_velocity, strike_velocity_b;
  logic [15:0]        strike_count, strike_count_b;

  drum_strike_detector u_dut (
    .clk(clk), .reset(reset), .sample_strobe(sample_strobe),
    .euler_valid(euler_valid), .gyro_valid(gyro_valid), .link_error(link_error),
    .yaw(yaw), .gyro_y(gyro_y),
    .strike_valid(strike_valid), .strike_zone(strike_zone),
    .strike_velocity(strike_velocity), .strike_count(strike_count), .busy(busy)
  );

  // second instance: coarse velocity shift and a counter preset near wrap
  drum_strike_detector #(.VEL_SHIFT(15), .COUNT_RESET(16'hFFF0)) u_dut_b (
    .clk(clk), .reset(reset), .sample_strobe(sample_strobe),
    .euler_valid(euler_valid), .gyro_valid(gyro_valid), .link_error(link_error),
    .yaw(yaw), .gyro_y(gyro_y),
    .strike_valid(strike_valid_b), .strike_zone(strike_zone_b),
    .strike_velocity(strike_velocity_b), .strike_count(strike_count_b), .busy(busy_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: phase 0 idle, 1 swinging, 2 cooling down
  int          m_phase = 0;
  int          m_swing[$];
  int          m_zone  = 0;
  int          m_cool  = 0;
  logic        e_valid = 1'b0, e_busy = 1'b0;
  logic [1:0]  e_zone  = '0;
  logic [6:0]  e_vel   = '0, e_vel_b = '0;
  logic [15:0] e_cnt   = '0, e_cnt_b = 16'hFFF0;

  function automatic int zone_ref(int y);
    if (y < -4500) return 0;
    if (y < 0)     return 1;
    if (y < 4500)  return 2;
    return 3;
  endfunction

  function automatic int vel_ref(int pk, int div);
    int v;
    v = (-pk) / div;
    if (v > 127) v = 127;
    if (v == 0)  v = 1;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int gi, yi, pk;
    bit ok;
    gi = int'(gyro_y);
    yi = int'(yaw);
    e_valid = 1'b0;
    if (reset) begin
      m_phase = 0; m_swing.delete();
      e_zone = '0; e_vel = '0; e_vel_b = '0; e_cnt = '0; e_cnt_b = 16'hFFF0;
    end else if (link_error) begin
      m_phase = 0; m_swing.delete();
    end else if (sample_strobe) begin
      ok = euler_valid && gyro_valid;
      case (m_phase)
        0: if (ok && gi < -3000) begin
             m_phase = 1;
             m_swing.delete();
             m_swing.push_back(gi);
             m_zone = zone_ref(yi);
           end
        1: if (!ok) begin
             m_phase = 0;
           end else if (gi > -500) begin
             pk = 0;
             foreach (m_swing[i]) if (m_swing[i] < pk) pk = m_swing[i];
             e_valid = 1'b1;
             e_zone  = 2'(m_zone);
             e_vel   = 7'(vel_ref(pk, 256));
             e_vel_b = 7'(vel_ref(pk, 32768));
             e_cnt   = e_cnt + 16'd1;
             e_cnt_b = e_cnt_b + 16'd1;
             m_phase = 2; m_cool = 4;
           end else begin
             m_swing.push_back(gi);
             // first sample plus 16 more without release: give up
             if (m_swing.size() == 17) begin m_phase = 2; m_cool = 4; end
           end
        default: begin
             m_cool--;
             if (m_cool == 0) m_phase = 0;
           end
      endcase
    end
    e_busy = (m_phase != 0);
  endtask

  task automatic compare_all();
    chk("valid",   int'(strike_valid),      int'(e_valid));
    chk("zone",    int'(strike_zone),       int'(e_zone));
    chk("vel",     int'(strike_velocity),   int'(e_vel));
    chk("count",   int'(strike_count),      int'(e_cnt));
    chk("busy",    int'(busy),              int'(e_busy));
    chk("valid_b", int'(strike_valid_b),    int'(e_valid));
    chk("vel_b",   int'(strike_velocity_b), int'(e_vel_b));
    chk("count_b", int'(strike_count_b),    int'(e_cnt_b));
  endtask

  task automatic cyc(input bit rst, input bit st, input bit ev, input bit gv,
                     input bit le, input int y, input int g);
    reset = rst; sample_strobe = st; euler_valid = ev; gyro_valid = gv;
    link_error = le; yaw = 16'(y); gyro_y = 16'(g);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic good(input int g, input int y);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, y, g);
  endtask

  task automatic gap();
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
  endtask

  task automatic cool_down();
    repeat (4) good(0, 0);
  endtask

  int yaws[6]  = '{-4501, -4500, -1, 0, 4499, 4500};
  int zones[6] = '{0, 1, 1, 2, 2, 3};

  initial begin
    int g, sel;
    reset = 1'b1; sample_strobe = 1'b0; euler_valid = 1'b0; gyro_valid = 1'b0;
    link_error = 1'b0; yaw = '0; gyro_y = '0;
    @(negedge clk);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    chk("rst_count_lit", int'(strike_count), 0);
    chk("rst_busy_lit", int'(busy), 0);
    chk("rst_count_b_lit", int'(strike_count_b), 16'hFFF0);

    // basic strike
    good(-4000, 1000); good(-9000, 1000);
    chk("basic_busy_lit", int'(busy), 1);
    good(-200, 1000);
    chk("basic_valid_lit", int'(strike_valid), 1);
    chk("basic_zone_lit", int'(strike_zone), 2);
    chk("basic_vel_lit", int'(strike_velocity), 35);
    chk("basic_count_lit", int'(strike_count), 1);
    chk("model_vel_lit", int'(e_vel), 35);
    gap();
    chk("basic_pulse_lit", int'(strike_valid), 0);
    cool_down();
    chk("basic_idle_lit", int'(busy), 0);

    // zone boundaries
    for (int i = 0; i < 6; i++) begin
      good(-4000, yaws[i]); good(-100, 0);
      chk("zone_lit", int'(strike_zone), zones[i]);
      chk("model_zone_lit", int'(e_zone), zones[i]);
      cool_down();
    end
    good(-32768, 0); good(0, 0);
    chk("vel_max_lit", int'(strike_velocity), 127);
    chk("vel_max_b_lit", int'(strike_velocity_b), 1);
    cool_down();

    // timeout
    repeat (17) good(-5000, 0);
    chk("timeout_busy_lit", int'(busy), 1);
    chk("timeout_count_lit", int'(strike_count), 8);
    repeat (3) good(0, 0);
    chk("timeout_cool_lit", int'(busy), 1);
    good(0, 0);
    chk("timeout_done_lit", int'(busy), 0);
    good(-4000, 0); good(-100, 0);
    chk("timeout_ev_lit", int'(strike_valid), 1);
    chk("timeout_vel_lit", int'(strike_velocity), 15);

    // refractory
    repeat (3) good(-8000, 0);
    chk("refr_busy_lit", int'(busy), 1);
    good(-8000, 0);
    chk("refr_idle_lit", int'(busy), 0);
    good(-8000, 0);
    chk("refr_start_lit", int'(busy), 1);
    good(-100, 0);
    chk("refr_vel_lit", int'(strike_velocity), 31);
    cool_down();

    // aborts and exact thresholds
    good(-4000, 0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, -9000);
    chk("abort_valid_lit", int'(busy), 0);
    good(-4000, 0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 0, 0);
    chk("abort_link_lit", int'(busy), 0);
    chk("abort_link_cnt_lit", int'(strike_count), 10);
    good(-4000, 0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0, -100);
    chk("abort_rst_lit", int'(busy), 0);
    chk("abort_rst_valid_lit", int'(strike_valid), 0);
    good(-3000, 0);
    chk("thresh_start_lit", int'(busy), 0);
    good(-3001, 0); good(-500, 0);
    chk("thresh_rel_lit", int'(strike_valid), 0);
    good(-499, 0);
    chk("thresh_ev_lit", int'(strike_valid), 1);
    chk("vel_min_b_lit", int'(strike_velocity_b), 1);
    chk("vel_3001_lit", int'(strike_velocity), 11);
    cool_down();

    // counter wrap on the preset instance
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    repeat (16) begin
      good(-4000, 0); good(0, 0);
      cool_down();
    end
    chk("wrap_b_lit", int'(strike_count_b), 0);
    chk("wrap_a_lit", int'(strike_count), 16);
    chk("model_wrap_lit", int'(e_cnt_b), 0);

    // random packets
    for (int n = 0; n < 20000; n++) begin
      sel = int'($urandom_range(7, 0));
      case (sel)
        0, 1:    g = -32768 + int'($urandom_range(29767, 0));
        2, 6, 7: g = -3000 + int'($urandom_range(2500, 0));
        3:       g = -499 + int'($urandom_range(33266, 0));
        4: begin
             case ($urandom_range(4, 0))
               0: g = -3000;
               1: g = -3001;
               2: g = -500;
               3: g = -499;
               default: g = -32768;
             endcase
           end
        default: g = int'($urandom_range(65535, 0)) - 32768;
      endcase
      cyc($urandom_range(2999, 0) == 0,
          $urandom_range(2, 0) != 0,
          $urandom_range(15, 0) != 0,
          $urandom_range(15, 0) != 0,
          $urandom_range(63, 0) == 0,
          int'($urandom_range(65535, 0)) - 32768,
          g);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/drum_strike_detector.md
# drum_strike_detector

Consumes the per-packet Euler/gyro sample stream produced by the Arduino SPI receive stage and detects discrete "drum strike" gestures. A strike is a downward swing on gyro Y that crosses a strike threshold and then relaxes past a release threshold. Each strike is reported as a one-cycle event carrying a yaw-derived zone (0–3) and a 7-bit velocity taken from the swing's peak rate. The block sits between the SPI receiver and the sound/playback control logic.

## Interface
- STRIKE_THRESH, -16'sd3000: gyro_y strictly below this value starts a strike.
- RELEASE_THRESH, -16'sd500: gyro_y strictly above this value ends a strike.
- MAX_STRIKE_SAMPLES, 16: number of STRIKE-state samples after which the strike is aborted.
- REFRACT_SAMPLES, 4: number of samples ignored after a strike ends or aborts.
- VEL_SHIFT, 8: right shift applied to the peak magnitude to form velocity.
- ZONE_B0 / ZONE_B1 / ZONE_B2, -16'sd4500 / 16'sd0 / 16'sd4500: yaw zone boundaries, in units of 0.01°.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- sample_strobe  in  1  one-cycle pulse marking a new packet on the data inputs.
- euler_valid  in  1  yaw data valid; sampled only when sample_strobe=1.
- gyro_valid  in  1  gyro data valid; sampled only when sample_strobe=1.
- link_error  in  1  header error from the receiver; level-sensitive.
- yaw  in  16 signed  yaw, 0.01°/LSB.
- gyro_y  in  16 signed  pitch-axis rate.
- strike_valid  out  1  one-cycle strike event.
- strike_zone  out  2  zone of the last strike.
- strike_velocity  out  7  velocity of the last strike, 1..127.
- strike_count  out  16  total emitted strikes; wraps modulo 2^16.
- busy  out  1  high when the state is not IDLE.

## Operation
- A sample is "good" when sample_strobe & euler_valid & gyro_valid & !link_error.
- States are IDLE, STRIKE and REFRACT. All transitions occur only on strobe cycles, except the link_error abort.
- **IDLE:**
  - On a good sample with gyro_y < STRIKE_THRESH: latch peak=gyro_y, latch zone from the yaw of that sample, clear the sample counter, go to STRIKE.
  - All other samples: stay in IDLE.
- **STRIKE**, evaluated in this priority order:
  1. Sample not good (strobe high but a valid flag low): abort to IDLE, no event.
  2. gyro_y > RELEASE_THRESH: emit the event and go to REFRACT with refract counter = REFRACT_SAMPLES.
  3. Otherwise: set peak = min(peak, gyro_y) and increment the sample counter. When the counter reaches MAX_STRIKE_SAMPLES, abort to REFRACT with no event.
- **REFRACT:** each strobe decrements the refract counter, regardless of sample validity. The strobe that decrements it to 0 moves the state to IDLE; that sample is not evaluated for a new strike.
- **link_error abort:** link_error=1 in any cycle forces IDLE and clears the counters. No event is emitted and strike outputs hold.
- **Zone:** yaw < ZONE_B0 → 0; yaw < ZONE_B1 → 1; yaw < ZONE_B2 → 2; otherwise 3. Comparisons are signed.
- **Velocity:**
  - mag = -peak, computed at 17 bits so that -32768 maps to 32768.
  - v = mag >> VEL_SHIFT, saturated to 127.
  - If v = 0, report 1 (a strike is never silent).
- **Event:** strike_zone and strike_velocity are updated together with strike_valid. They hold until the next event. strike_count increments with each event.

## Timing
- Reset values: state IDLE; strike_valid=0, strike_zone=0, strike_velocity=0, strike_count=0, busy=0; internal peak and counters = 0.
- All outputs are registered.
- A strobe at cycle N affects state at the edge ending cycle N. strike_valid is high for exactly cycle N+1, with zone and velocity valid in the same cycle.
- busy reflects the registered state: it rises in the cycle after the starting strobe.
- sample_strobe held high in consecutive cycles is treated as consecutive samples. No minimum spacing is required.
- reset has priority over link_error and strobe. Reset mid-STRIKE emits no event.
- In the release sample, peak is not updated: release values are above the threshold and cannot be the minimum.
- strike_count wraps from 0xFFFF to 0x0000.

## Test plan
1. **Basic strike.** Reset, then apply good samples with gyro_y = -4000 (yaw=1000), then -9000, then -200. Expect strike_valid for 1 cycle after the third strobe, zone=2, velocity=35 (9000>>8), count=1.
2. **Zones and boundaries.** Run strikes at yaw = -4501, -4500, -1, 0, 4499 and 4500. Expect zones 0, 1, 1, 2, 2, 3. A peak of -32768 gives velocity 127.
3. **Timeout.** Apply gyro_y = -5000 for 17 samples. Expect no event and busy still high. Then apply 4 more strobes: busy drops after the 4th. A following -4000 / -100 pair yields one event.
4. **Refractory.** Right after a strike event, apply -8000 on each of the next 4 samples. Expect no new strike. On the 5th sample, -8000 starts a strike.
5. **Aborts.** In STRIKE, send a strobe with gyro_valid=0, or assert link_error for 1 cycle, or assert reset. In each case expect IDLE, no event and an unchanged count. Also check that gyro_y = -3000 exactly does not start a strike and -500 exactly does not release one.
6. **Min velocity and wrap.** Set VEL_SHIFT=15 with a peak of -3001: expect velocity 1. Preload via 65536 strikes, or force the counter to 0xFFFF: the next strike reads 0x0000.
